// File: rtl/siphash_regs_responder_if.sv
// Register bus between the cuckatoo sequencer (master) and the SipHash responder (slave).
interface siphash_regs_responder_if;
   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 64;

   logic              cs;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] write_data;
   logic [DATA_W-1:0] read_data;
   logic              ready;
   logic              word_valid;

   modport master (
      output cs, we, addr, write_data,
      input  read_data, ready, word_valid
   );

   modport slave (
      input  cs, we, addr, write_data,
      output read_data, ready, word_valid
   );
endinterface

// File: rtl/siphash_regs_responder.sv
// Register-mapped SipHash-c-d engine: keys load v0..v3 directly, one SipRound per cycle.
module siphash_regs_responder #(
   parameter int unsigned C_ROUNDS  = 2,
   parameter int unsigned D_ROUNDS  = 4,
   parameter logic [63:0] FINAL_XOR = 64'hff
) (
   input logic                     clk,
   input logic                     reset,
   siphash_regs_responder_if.slave bus
);
   localparam int unsigned DATA_W     = 64;
   localparam int unsigned MAX_ROUNDS = (C_ROUNDS > D_ROUNDS) ? C_ROUNDS : D_ROUNDS;
   localparam int unsigned CNT_W      = $clog2(MAX_ROUNDS + 1);

   localparam logic [7:0] ADDR_CTRL   = 8'h08;
   localparam logic [7:0] ADDR_STATUS = 8'h09;
   localparam logic [7:0] ADDR_KEY0   = 8'h10;
   localparam logic [7:0] ADDR_KEY1   = 8'h11;
   localparam logic [7:0] ADDR_KEY2   = 8'h12;
   localparam logic [7:0] ADDR_KEY3   = 8'h13;
   localparam logic [7:0] ADDR_NONCE  = 8'h18;
   localparam logic [7:0] ADDR_WORD0  = 8'h20;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      INIT = 2'd1,
      COMP = 2'd2,
      FIN  = 2'd3
   } state_e;

   state_e                     state_q, state_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [3:0][DATA_W-1:0]     v_q, v_d;
   logic [3:0][DATA_W-1:0]     key_q, key_d;
   logic [DATA_W-1:0]          nonce_q, nonce_d;
   logic [DATA_W-1:0]          result_q, result_d;
   logic                       word_valid_q, word_valid_d;

   logic                       wr_en, rd_en, ready_c;
   logic                       cmd_init, cmd_comp, cmd_fin;
   logic                       first_c, last_comp_c, last_fin_c;
   logic [3:0][DATA_W-1:0]     rin, rout;
   logic [DATA_W-1:0]          rd_data_c;

   // One SipRound: ARX network with rotations 13, 32, 16, 21, 17, 32.
   function automatic logic [3:0][DATA_W-1:0] sip_round(input logic [3:0][DATA_W-1:0] v);
      logic [DATA_W-1:0] a, b, c, d;
      a = v[0]; b = v[1]; c = v[2]; d = v[3];
      a = a + b;  b = {b[50:0], b[63:51]};  b = b ^ a;  a = {a[31:0], a[63:32]};
      c = c + d;  d = {d[47:0], d[63:48]};  d = d ^ c;
      a = a + d;  d = {d[42:0], d[63:43]};  d = d ^ a;
      c = c + b;  b = {b[46:0], b[63:47]};  b = b ^ c;  c = {c[31:0], c[63:32]};
      return {d, c, b, a};
   endfunction

   // Bus decode and command selection; init beats compress beats finalize.
   always_comb begin
      wr_en       = bus.cs & bus.we;
      rd_en       = bus.cs & ~bus.we;
      ready_c     = (state_q == IDLE);
      cmd_init    = wr_en && (bus.addr == ADDR_CTRL) && ready_c && bus.write_data[0];
      cmd_comp    = wr_en && (bus.addr == ADDR_CTRL) && ready_c && !bus.write_data[0]
                    && bus.write_data[1];
      cmd_fin     = wr_en && (bus.addr == ADDR_CTRL) && ready_c && !bus.write_data[0]
                    && !bus.write_data[1] && bus.write_data[2];
      first_c     = (cnt_q == '0);
      last_comp_c = (cnt_q == CNT_W'(C_ROUNDS - 1));
      last_fin_c  = (cnt_q == CNT_W'(D_ROUNDS - 1));
   end

   // Round input folds in the nonce (compress) or the finalize constant on the first round.
   always_comb begin
      rin = v_q;
      if (state_q == COMP && first_c) rin[3] = v_q[3] ^ nonce_q;
      if (state_q == FIN && first_c)  rin[2] = v_q[2] ^ FINAL_XOR;
      rout = sip_round(rin);
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (cmd_init)      state_d = INIT;
            else if (cmd_comp) state_d = COMP;
            else if (cmd_fin)  state_d = FIN;
         end
         INIT:    state_d = IDLE;
         COMP:    if (last_comp_c) state_d = IDLE;
         FIN:     if (last_fin_c)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath next values: register writes, round counter and per-state updates.
   always_comb begin
      cnt_d        = cnt_q;
      v_d          = v_q;
      key_d        = key_q;
      nonce_d      = nonce_q;
      result_d     = result_q;
      word_valid_d = word_valid_q;

      if (wr_en && bus.addr[7:2] == ADDR_KEY0[7:2]) key_d[bus.addr[1:0]] = bus.write_data;
      if (wr_en && bus.addr == ADDR_NONCE && ready_c) nonce_d = bus.write_data;

      case (state_q)
         IDLE: cnt_d = '0;
         INIT: begin
            v_d          = key_q;
            word_valid_d = 1'b0;
         end
         COMP: begin
            cnt_d = cnt_q + CNT_W'(1);
            v_d   = rout;
            if (last_comp_c) v_d[0] = rout[0] ^ nonce_q;
         end
         FIN: begin
            cnt_d = cnt_q + CNT_W'(1);
            v_d   = rout;
            if (last_fin_c) begin
               result_d     = rout[0] ^ rout[1] ^ rout[2] ^ rout[3];
               word_valid_d = 1'b1;
            end
         end
         default: cnt_d = '0;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q        <= '0;
         v_q          <= '0;
         key_q        <= '0;
         nonce_q      <= '0;
         result_q     <= '0;
         word_valid_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         v_q          <= v_d;
         key_q        <= key_d;
         nonce_q      <= nonce_d;
         result_q     <= result_d;
         word_valid_q <= word_valid_d;
      end
   end

   // Combinational read mux from the current (pre-edge) register state.
   always_comb begin
      rd_data_c = '0;
      if (rd_en) begin
         case (bus.addr)
            ADDR_STATUS: rd_data_c = DATA_W'({word_valid_q, ready_c});
            ADDR_KEY0:   rd_data_c = key_q[0];
            ADDR_KEY1:   rd_data_c = key_q[1];
            ADDR_KEY2:   rd_data_c = key_q[2];
            ADDR_KEY3:   rd_data_c = key_q[3];
            ADDR_NONCE:  rd_data_c = nonce_q;
            ADDR_WORD0:  rd_data_c = result_q;
            default:     rd_data_c = '0;
         endcase
      end
   end

   assign bus.read_data  = rd_data_c;
   assign bus.ready      = ready_c;
   assign bus.word_valid = word_valid_q;
endmodule

// File: tb/tb_siphash_regs_responder.sv
// Bench for siphash_regs_responder: a 2-4 and a 1-3 instance driven with identical bus traffic.
module tb_siphash_regs_responder;
   logic        clk = 1'b0;
   logic        reset;
   logic        d_cs, d_we;
   logic [7:0]  d_addr;
   logic [63:0] d_wd;

   int n_pass  = 0;
   int n_total = 0;

   siphash_regs_responder_if bus_a ();
   siphash_regs_responder_if bus_b ();

   assign bus_a.cs = d_cs;  assign bus_a.we = d_we;
   assign bus_a.addr = d_addr;  assign bus_a.write_data = d_wd;
   assign bus_b.cs = d_cs;  assign bus_b.we = d_we;
   assign bus_b.addr = d_addr;  assign bus_b.write_data = d_wd;

   siphash_regs_responder #(.C_ROUNDS(2), .D_ROUNDS(4), .FINAL_XOR(64'hff)) dut_a (
      .clk(clk), .reset(reset), .bus(bus_a.slave));
   siphash_regs_responder #(.C_ROUNDS(1), .D_ROUNDS(3), .FINAL_XOR(64'hff)) dut_b (
      .clk(clk), .reset(reset), .bus(bus_b.slave));

   always #5 clk = ~clk;

   // ---------------- reference algorithm (C-style SipHash, keys load v directly) ----------
   function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
      return (x << n) | (x >> (64 - n));
   endfunction

   function automatic logic [3:0][63:0] sipround(input logic [3:0][63:0] v);
      v[0] += v[1]; v[1] = rotl(v[1], 13); v[1] ^= v[0]; v[0] = rotl(v[0], 32);
      v[2] += v[3]; v[3] = rotl(v[3], 16); v[3] ^= v[2];
      v[0] += v[3]; v[3] = rotl(v[3], 21); v[3] ^= v[0];
      v[2] += v[1]; v[1] = rotl(v[1], 17); v[1] ^= v[2]; v[2] = rotl(v[2], 32);
      return v;
   endfunction

   function automatic logic [3:0][63:0] compress(input logic [3:0][63:0] v,
                                                 input logic [63:0] m, input int c);
      v[3] ^= m;
      for (int r = 0; r < c; r++) v = sipround(v);
      v[0] ^= m;
      return v;
   endfunction

   function automatic logic [3:0][63:0] fin_rounds(input logic [3:0][63:0] v, input int d);
      v[2] ^= 64'hff;
      for (int r = 0; r < d; r++) v = sipround(v);
      return v;
   endfunction

   function automatic logic [63:0] xor4(input logic [3:0][63:0] v);
      return v[0] ^ v[1] ^ v[2] ^ v[3];
   endfunction

   function automatic logic [63:0] siphash(input logic [3:0][63:0] k, input logic [63:0] m,
                                           input int c, input int d);
      return xor4(fin_rounds(compress(k, m, c), d));
   endfunction

   function automatic int c_of(input int i); return (i == 0) ? 2 : 1; endfunction
   function automatic int d_of(input int i); return (i == 0) ? 4 : 3; endfunction

   // ---------------- transaction-level model: command effect lands when busy expires -----
   logic [63:0]      m_key   [2][4];
   logic [63:0]      m_nonce [2];
   logic [3:0][63:0] m_v     [2];
   logic [63:0]      m_word  [2];
   logic             m_wv    [2];
   int               m_busy  [2];
   int               m_cmd   [2];
   int               m_blen  [2];

   logic [3:0][63:0] t_v;
   logic [63:0]      t_w;
   logic             t_wv;
   int               t_b, t_len, t_cmd;

   // Model update on every bus edge, mirroring what each instance must commit.
   always @(posedge clk or posedge reset) begin : model
      if (reset) begin
         for (int i = 0; i < 2; i++) begin
            m_nonce[i] <= '0; m_v[i] <= '0; m_word[i] <= '0; m_wv[i] <= 1'b0;
            m_busy[i] <= 0; m_cmd[i] <= 0; m_blen[i] <= 0;
            for (int j = 0; j < 4; j++) m_key[i][j] <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            t_v = m_v[i]; t_w = m_word[i]; t_wv = m_wv[i]; t_b = m_busy[i]; t_cmd = m_cmd[i];
            if (t_b == 1) begin
               case (m_cmd[i])
                  1: begin for (int j = 0; j < 4; j++) t_v[j] = m_key[i][j]; t_wv = 1'b0; end
                  2: t_v = compress(t_v, m_nonce[i], c_of(i));
                  3: begin t_v = fin_rounds(t_v, d_of(i)); t_w = xor4(t_v); t_wv = 1'b1; end
                  default: ;
               endcase
            end
            if (t_b > 0) t_b = t_b - 1;
            if (d_cs && d_we) begin
               if (d_addr >= 8'h10 && d_addr <= 8'h13) m_key[i][d_addr[1:0]] <= d_wd;
               if (d_addr == 8'h18 && m_busy[i] == 0) m_nonce[i] <= d_wd;
               if (d_addr == 8'h08 && m_busy[i] == 0 && d_wd[2:0] != 3'b000) begin
                  t_cmd = d_wd[0] ? 1 : (d_wd[1] ? 2 : 3);
                  t_len = (t_cmd == 1) ? 1 : ((t_cmd == 2) ? c_of(i) : d_of(i));
                  t_b   = t_len;
                  m_blen[i] <= t_len;
               end
            end
            m_v[i] <= t_v; m_word[i] <= t_w; m_wv[i] <= t_wv;
            m_busy[i] <= t_b; m_cmd[i] <= t_cmd;
         end
      end
   end

   function automatic logic [63:0] exp_rd(input int i);
      logic [63:0] r;
      r = '0;
      if (d_cs && !d_we) begin
         case (d_addr)
            8'h09:   r = 64'({m_wv[i], (m_busy[i] == 0)});
            8'h10:   r = m_key[i][0];
            8'h11:   r = m_key[i][1];
            8'h12:   r = m_key[i][2];
            8'h13:   r = m_key[i][3];
            8'h18:   r = m_nonce[i];
            8'h20:   r = m_word[i];
            default: r = '0;
         endcase
      end
      return r;
   endfunction

   // ---------------- checking and driving helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, required %h", name, act, exp);
   endtask

   task automatic bus_idle();
      d_cs = 1'b0; d_we = 1'b0; d_addr = 8'h00; d_wd = '0;
   endtask

   task automatic wr(input logic [7:0] a, input logic [63:0] data);
      d_cs = 1'b1; d_we = 1'b1; d_addr = a; d_wd = data;
      @(posedge clk); #1;
      bus_idle();
   endtask

   task automatic rd(input logic cs, input logic [7:0] a,
                     output logic [63:0] ra, output logic [63:0] rb);
      d_cs = cs; d_we = 1'b0; d_addr = a; d_wd = '0;
      @(negedge clk);
      ra = bus_a.read_data; rb = bus_b.read_data;
      @(posedge clk); #1;
      bus_idle();
   endtask

   // Poll STATUS until both instances report ready; returns busy cycles seen per instance.
   task automatic poll(output int ba, output int bb);
      logic done;
      ba = 0; bb = 0; done = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
         d_cs = 1'b1; d_we = 1'b0; d_addr = 8'h09; d_wd = '0;
         @(negedge clk);
         if (!bus_a.read_data[0]) ba++;
         if (!bus_b.read_data[0]) bb++;
         if (bus_a.read_data[0] && bus_b.read_data[0]) done = 1'b1;
         @(posedge clk); #1;
      end
      check("poll_done", 64'(done), 64'd1);
      bus_idle();
   endtask

   logic [3:0][63:0] sk, k1234;
   logic [63:0]      ra, rb;
   int               ba, bb, run_a, run_b;

   initial begin
      reset = 1'b1;
      bus_idle();
      run_a = 0; run_b = 0;

      // Per-cycle compare of ready, word_valid and read_data against the model.
      fork
         forever begin
            @(negedge clk);
            if (reset) begin
               run_a = 0; run_b = 0;
            end else begin
               check("cyc_ready_a", 64'(bus_a.ready), 64'(m_busy[0] == 0));
               check("cyc_ready_b", 64'(bus_b.ready), 64'(m_busy[1] == 0));
               check("cyc_wv_a", 64'(bus_a.word_valid), 64'(m_wv[0]));
               check("cyc_wv_b", 64'(bus_b.word_valid), 64'(m_wv[1]));
               check("cyc_rdata_a", bus_a.read_data, exp_rd(0));
               check("cyc_rdata_b", bus_b.read_data, exp_rd(1));
               if (!bus_a.ready) run_a++;
               else if (run_a != 0) begin check("busy_len_a", 64'(run_a), 64'(m_blen[0])); run_a = 0; end
               if (!bus_b.ready) run_b++;
               else if (run_b != 0) begin check("busy_len_b", 64'(run_b), 64'(m_blen[1])); run_b = 0; end
            end
         end
         begin
            #500000;
            $display("FAIL watchdog: simulation did not complete");
            $fatal(1);
         end
      join_none

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state.
      rd(1'b1, 8'h09, ra, rb);
      check("reset_status_a", ra, 64'd1);  check("reset_status_b", rb, 64'd1);
      rd(1'b1, 8'h20, ra, rb);
      check("reset_word_a", ra, 64'd0);

      // Pin the reference against published SipHash-2-4 vectors (key 00..0f).
      sk[0] = 64'h0706050403020100 ^ 64'h736f6d6570736575;
      sk[1] = 64'h0f0e0d0c0b0a0908 ^ 64'h646f72616e646f6d;
      sk[2] = 64'h0706050403020100 ^ 64'h6c7967656e657261;
      sk[3] = 64'h0f0e0d0c0b0a0908 ^ 64'h7465646279746573;
      check("pin_model_empty", siphash(sk, 64'h0, 2, 4), 64'h726fdb47dd0e0e31);
      check("pin_model_1byte", siphash(sk, 64'h0100000000000000, 2, 4), 64'h74f839c593dc67fd);

      // Finalize straight after reset works on zero state.
      wr(8'h08, 64'd4); poll(ba, bb);
      check("fin_no_init_busy_a", 64'(ba), 64'd4);
      rd(1'b1, 8'h20, ra, rb);
      check("fin_no_init_a", ra, xor4(fin_rounds('0, 4)));
      check("fin_no_init_b", rb, xor4(fin_rounds('0, 3)));

      // Published vector through the hardware.
      for (int j = 0; j < 4; j++) wr(8'(8'h10 + j), sk[j]);
      wr(8'h08, 64'd1); poll(ba, bb);
      wr(8'h18, 64'd0);
      wr(8'h08, 64'd2); poll(ba, bb);
      wr(8'h08, 64'd4); poll(ba, bb);
      rd(1'b1, 8'h20, ra, rb);
      check("std_word_a", ra, 64'h726fdb47dd0e0e31);
      check("std_word_b", rb, siphash(sk, 64'h0, 1, 3));

      // Full sequence with keys 1..4, nonce 111.
      k1234[0] = 64'd1; k1234[1] = 64'd2; k1234[2] = 64'd3; k1234[3] = 64'd4;
      for (int j = 0; j < 4; j++) wr(8'(8'h10 + j), k1234[j]);
      wr(8'h08, 64'd1); poll(ba, bb);
      check("init_busy_a", 64'(ba), 64'd1);  check("init_busy_b", 64'(bb), 64'd1);
      wr(8'h18, 64'd111);
      wr(8'h08, 64'd2); poll(ba, bb);
      check("comp_busy_a", 64'(ba), 64'd2);  check("comp_busy_b", 64'(bb), 64'd1);
      wr(8'h08, 64'd4); poll(ba, bb);
      check("fin_busy_a", 64'(ba), 64'd4);   check("fin_busy_b", 64'(bb), 64'd3);
      rd(1'b1, 8'h20, ra, rb);
      check("full_word_a", ra, siphash(k1234, 64'd111, 2, 4));
      check("full_word_b", rb, siphash(k1234, 64'd111, 1, 3));
      rd(1'b1, 8'h09, ra, rb);
      check("full_status_a", ra, 64'd3);

      // Busy rejection: NONCE and CTRL writes during compress.
      wr(8'h08, 64'd1); poll(ba, bb);
      wr(8'h08, 64'd2);
      wr(8'h18, 64'd5);
      wr(8'h08, 64'd4);
      poll(ba, bb);
      rd(1'b1, 8'h18, ra, rb);
      check("busy_nonce_a", ra, 64'd111);  check("busy_nonce_b", rb, 64'd111);
      wr(8'h08, 64'd4); poll(ba, bb);
      rd(1'b1, 8'h20, ra, rb);
      check("busy_word_a", ra, siphash(k1234, 64'd111, 2, 4));
      check("busy_word_b", rb, m_word[1]);

      // Priority (7 runs init only) and CTRL=0 no-op.
      wr(8'h08, 64'd7); poll(ba, bb);
      check("prio_busy_a", 64'(ba), 64'd1);  check("prio_busy_b", 64'(bb), 64'd1);
      rd(1'b1, 8'h09, ra, rb);
      check("prio_status_a", ra, 64'd1);     check("prio_status_b", rb, 64'd1);
      rd(1'b1, 8'h20, ra, rb);
      check("prio_word_kept_a", ra, siphash(k1234, 64'd111, 2, 4));
      wr(8'h08, 64'd0);
      rd(1'b1, 8'h09, ra, rb);
      check("noop_status_a", ra, 64'd1);     check("noop_status_b", rb, 64'd1);

      // Register readback and zero reads.
      wr(8'h12, 64'hDEADBEEF_CAFEF00D);
      rd(1'b1, 8'h12, ra, rb);
      check("key2_rb_a", ra, 64'hDEADBEEF_CAFEF00D);  check("key2_rb_b", rb, 64'hDEADBEEF_CAFEF00D);
      rd(1'b1, 8'h08, ra, rb);  check("ctrl_read_zero", ra, 64'd0);
      rd(1'b1, 8'h7F, ra, rb);  check("unmapped_zero", ra, 64'd0);
      rd(1'b0, 8'h12, ra, rb);  check("cs_low_zero", ra, 64'd0);

      // Reset during the second finalize round.
      wr(8'h08, 64'd1); poll(ba, bb);
      wr(8'h08, 64'd4);
      @(posedge clk); #1;
      #2 reset = 1'b1;
      @(posedge clk); #3 reset = 1'b0;
      rd(1'b1, 8'h09, ra, rb);
      check("rst_status_a", ra, 64'd1);  check("rst_status_b", rb, 64'd1);
      rd(1'b1, 8'h20, ra, rb);
      check("rst_word_a", ra, 64'd0);    check("rst_word_b", rb, 64'd0);
      for (int j = 0; j < 4; j++) begin
         rd(1'b1, 8'(8'h10 + j), ra, rb);
         check($sformatf("rst_key%0d_a", j), ra, 64'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
